// File: rtl/ifetch_pkg.sv
// Shared types and field positions for the fetch stage.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } ifetch_state_t;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;

  // Word alignment; sign-extended when applied to wider address buses.
  localparam logic [INSTR_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int JIDX_MSB   = 25;
  localparam int JIDX_LSB   = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
module next_pc_logic
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]       pc,
  input  logic [JIDX_MSB:JIDX_LSB] target_field,
  input  logic                    jump,
  input  logic                    branch,
  input  logic                    zero,
  output logic [ADDR_W-1:0]       pc_plus4,
  output logic [ADDR_W-1:0]       next_pc
);

  logic [IMM_MSB:IMM_LSB] imm;
  logic [ADDR_W-1:0]      branch_offset;
  logic [ADDR_W-1:0]      branch_target;
  logic [ADDR_W-1:0]      jump_target;

  assign imm           = target_field[IMM_MSB:IMM_LSB];
  assign pc_plus4      = pc + ADDR_W'(4);
  assign branch_offset = {{(ADDR_W-18){imm[IMM_MSB]}}, imm, 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  // The region bits come from PC+4, so a jump in the last word of a region lands in the next one.
  assign jump_target   = {pc_plus4[ADDR_W-1:28], target_field, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, IDLE/FETCH/EXEC handshake FSM and instruction register.
// Optional macro IFETCH_STALL_CNT_EN adds the FetchWaitCnt memory-wait counter.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                Clk,
  input  logic                Rst_n,
  output logic                IMemReq,
  output logic [ADDR_W-1:0]   IMemAddr,
  input  logic                IMemAck,
  input  logic [INSTR_W-1:0]  IMemRdata,
  input  logic                Stall,
  input  logic                Jump,
  input  logic                Branch,
  input  logic                Zero,
  output logic [INSTR_W-1:0]  Instr,
  output logic [OPCODE_W-1:0] Opcode,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   PCPlus4,
  output logic                InstrValid,
  output ifetch_state_t       State
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]         FetchWaitCnt
`endif
);

  localparam logic [ADDR_W-1:0] PC_MASK       = ADDR_W'($signed(PC_ALIGN_MASK));
  localparam logic [ADDR_W-1:0] RESET_PC_WORD = RESET_PC & PC_MASK;

  // Handshake: IMemReq rises on entry to FETCH and holds with IMemAddr constant
  // until a rising edge sees IMemAck=1; IMemAck is ignored in every other state.
  ifetch_state_t     state;
  logic [ADDR_W-1:0] next_pc;

  next_pc_logic #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc          (PC),
    .target_field(Instr[JIDX_MSB:JIDX_LSB]),
    .jump        (Jump),
    .branch      (Branch),
    .zero        (Zero),
    .pc_plus4    (PCPlus4),
    .next_pc     (next_pc)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      PC         <= RESET_PC_WORD;
      Instr      <= '0;
      IMemReq    <= 1'b0;
      InstrValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          IMemReq <= 1'b1;
        end
        FETCH: begin
          if (IMemAck) begin
            Instr      <= IMemRdata;
            IMemReq    <= 1'b0;
            InstrValid <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (!Stall) begin
            PC         <= next_pc & PC_MASK;
            InstrValid <= 1'b0;
            IMemReq    <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          state      <= IDLE;
          IMemReq    <= 1'b0;
          InstrValid <= 1'b0;
        end
      endcase
    end
  end

  assign IMemAddr = PC;
  assign Opcode   = Instr[OPCODE_MSB:OPCODE_LSB];
  assign State    = state;

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      FetchWaitCnt <= '0;
    end else if (state == FETCH && !IMemAck && FetchWaitCnt != 32'hFFFF_FFFF) begin
      FetchWaitCnt <= FetchWaitCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an address/instruction scoreboard.
module tb_instruction_fetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RST_PC    = 32'h0000_0010;
  localparam logic [31:0] RST_PC_HI = 32'h4000_0000;

  // clock / reset
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic        IMemAck = 1'b0;
  logic [31:0] IMemRdata = '0;
  logic        Stall = 1'b0;
  logic        Jump = 1'b0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;

  logic          IMemReq, InstrValid;
  logic [31:0]   IMemAddr, Instr, PC, PCPlus4;
  logic [5:0]    Opcode;
  ifetch_state_t State;

  logic          h_req, h_valid;
  logic [31:0]   h_addr, h_instr, h_pc, h_pc4;
  logic [5:0]    h_opcode;
  ifetch_state_t h_state;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0]   FetchWaitCnt, h_cnt;
`endif

  instruction_fetch #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemAck(IMemAck), .IMemRdata(IMemRdata), .Stall(Stall), .Jump(Jump),
    .Branch(Branch), .Zero(Zero), .Instr(Instr), .Opcode(Opcode), .PC(PC),
    .PCPlus4(PCPlus4), .InstrValid(InstrValid), .State(State)
`ifdef IFETCH_STALL_CNT_EN
    , .FetchWaitCnt(FetchWaitCnt)
`endif
  );

  // Second instance in the upper address region, driven by the same stimulus.
  instruction_fetch #(.ADDR_W(32), .RESET_PC(RST_PC_HI)) dut_hi (
    .Clk(Clk), .Rst_n(Rst_n), .IMemReq(h_req), .IMemAddr(h_addr),
    .IMemAck(IMemAck), .IMemRdata(IMemRdata), .Stall(Stall), .Jump(Jump),
    .Branch(Branch), .Zero(Zero), .Instr(h_instr), .Opcode(h_opcode), .PC(h_pc),
    .PCPlus4(h_pc4), .InstrValid(h_valid), .State(h_state)
`ifdef IFETCH_STALL_CNT_EN
    , .FetchWaitCnt(h_cnt)
`endif
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_hi_q[$];
  logic [31:0] instr_q[$];
  logic [31:0] exp_pc, exp_pc_hi, exp_wait, cur_instr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic j, input logic b, input logic z);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j) return {p4[31:28], ins[25:0], 2'b00};
    if (b && z) return p4 + {{14{ins[15]}}, ins[15:0], 2'b00};
    return p4;
  endfunction

  function automatic logic [31:0] pop_or_bad(inout logic [31:0] q[$]);
    if (q.size() == 0) return 32'hDEAD_BEEF;
    return q.pop_front();
  endfunction

  // driver: serve one fetch with a given number of wait states
  task automatic fetch(input logic [31:0] word, input int waits);
    logic [31:0] a, ah, e;
    int budget;
    budget = 0;
    while (IMemReq !== 1'b1 && budget < 20) begin
      @(negedge Clk);
      budget++;
    end
    check("req_rise", {31'b0, IMemReq}, 32'd1);
    a  = pop_or_bad(exp_q);
    ah = pop_or_bad(exp_hi_q);
    check("fetch_addr", IMemAddr, a);
    check("fetch_addr_hi", h_addr, ah);
    check("valid_in_fetch", {31'b0, InstrValid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      Jump   = 1'($urandom_range(0, 1));
      Branch = 1'($urandom_range(0, 1));
      Zero   = 1'($urandom_range(0, 1));
      @(negedge Clk);
      check("req_held", {31'b0, IMemReq}, 32'd1);
      check("addr_stable", IMemAddr, a);
    end
    IMemAck   = 1'b1;
    IMemRdata = word;
    instr_q.push_back(word);
    exp_wait  = exp_wait + 32'(waits);
    @(negedge Clk);
    IMemAck   = 1'b0;
    IMemRdata = $urandom;
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
    e = pop_or_bad(instr_q);
    cur_instr = e;
    check("instr", Instr, e);
    check("opcode", {26'b0, Opcode}, {26'b0, e[31:26]});
    check("valid_exec", {31'b0, InstrValid}, 32'd1);
    check("req_low_exec", {31'b0, IMemReq}, 32'd0);
    check("pc", PC, exp_pc);
    check("pc_plus4", PCPlus4, exp_pc + 32'd4);
    check("pc_hi", h_pc, exp_pc_hi);
`ifdef IFETCH_STALL_CNT_EN
    check("wait_cnt", FetchWaitCnt, exp_wait);
`endif
  endtask

  // driver: hold in EXEC for some stall cycles, then resolve next PC
  task automatic exec(input logic j, input logic b, input logic z, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      Stall  = 1'b1;
      Jump   = 1'($urandom_range(0, 1));
      Branch = 1'($urandom_range(0, 1));
      Zero   = 1'($urandom_range(0, 1));
      @(negedge Clk);
      check("stall_valid", {31'b0, InstrValid}, 32'd1);
      check("stall_no_req", {31'b0, IMemReq}, 32'd0);
      check("stall_pc", PC, exp_pc);
      check("stall_instr", Instr, cur_instr);
    end
    Stall = 1'b0; Jump = j; Branch = b; Zero = z;
    exp_pc    = model_next(exp_pc, cur_instr, j, b, z);
    exp_pc_hi = model_next(exp_pc_hi, cur_instr, j, b, z);
    exp_q.push_back(exp_pc);
    exp_hi_q.push_back(exp_pc_hi);
    @(negedge Clk);
    Jump = 1'b0; Branch = 1'b0; Zero = 1'b0;
  endtask

  initial begin
    exp_pc = RST_PC; exp_pc_hi = RST_PC_HI; exp_wait = '0; cur_instr = '0;
    repeat (2) @(negedge Clk);
    check("rst_req", {31'b0, IMemReq}, 32'd0);
    check("rst_pc", PC, RST_PC);
    check("rst_instr", Instr, 32'd0);
    check("rst_valid", {31'b0, InstrValid}, 32'd0);
    check("rst_state", {30'b0, State}, {30'b0, IDLE});
    Rst_n = 1'b1;
    exp_q.push_back(RST_PC);
    exp_hi_q.push_back(RST_PC_HI);
    check("idle_no_req", {31'b0, IMemReq}, 32'd0);
    @(negedge Clk);

    fetch(32'h2000_0000, 0); exec(1'b0, 1'b0, 1'b0, 0);  // 0x10 -> 0x14
    fetch(32'h0800_0040, 3); exec(1'b1, 1'b1, 1'b1, 0);  // jump wins -> 0x100
    fetch(32'h1000_FFFE, 0); exec(1'b0, 1'b1, 1'b1, 0);  // taken -> 0xFC
    fetch(32'h0800_0040, 0); exec(1'b1, 1'b0, 1'b0, 0);  // -> 0x100
    fetch(32'h1000_FFFE, 1); exec(1'b0, 1'b1, 1'b0, 0);  // not taken -> 0x104
    fetch(32'h0800_0000, 0); exec(1'b1, 1'b0, 1'b0, 0);  // -> 0x0
    fetch(32'h1000_FFFE, 2); exec(1'b0, 1'b1, 1'b1, 0);  // wraps -> 0xFFFF_FFFC
    fetch(32'h2000_0000, 0); exec(1'b0, 1'b0, 1'b0, 4);  // stall, then wraps -> 0x0

    // abandon an outstanding fetch with an asynchronous reset
    check("abort_req", {31'b0, IMemReq}, 32'd1);
    check("abort_addr", IMemAddr, pop_or_bad(exp_q));
    void'(pop_or_bad(exp_hi_q));
    repeat (2) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("async_req", {31'b0, IMemReq}, 32'd0);
    check("async_pc", PC, RST_PC);
    check("async_pc_hi", h_pc, RST_PC_HI);
    check("async_valid", {31'b0, InstrValid}, 32'd0);
    check("async_state", {30'b0, State}, {30'b0, IDLE});
    IMemAck = 1'b1;
    IMemRdata = 32'hFFFF_FFFF;
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("stray_ack_instr", Instr, 32'd0);
    check("stray_ack_valid", {31'b0, InstrValid}, 32'd0);
    check("post_rst_state", {30'b0, State}, {30'b0, FETCH});
    IMemAck = 1'b0;
    exp_q.delete(); exp_hi_q.delete(); instr_q.delete();
    exp_pc = RST_PC; exp_pc_hi = RST_PC_HI; exp_wait = '0;
    exp_q.push_back(RST_PC);
    exp_hi_q.push_back(RST_PC_HI);
    fetch(32'h8C00_0004, 1); exec(1'b0, 1'b0, 1'b0, 0);
    check("final_req", {31'b0, IMemReq}, 32'd1);
    check("final_addr", IMemAddr, pop_or_bad(exp_q));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
